// File: rtl/gyro_bias_calibrator.sv
`default_nettype none
// ============================================================================
//  Module   : gyro_bias_calibrator
//  Purpose  : Averages 2^CAL_LOG2 stationary gyro samples into a per-axis
//             bias estimate, with a motion check on each sample, then emits
//             bias-corrected, saturated rates through a two-stage pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module gyro_bias_calibrator #(
    parameter int CAL_LOG2      = 8,
    parameter int MOTION_THRESH = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        booting,
    input  logic        data_ready,
    input  logic [15:0] gyro_x_in,
    input  logic [15:0] gyro_y_in,
    input  logic [15:0] gyro_z_in,
    input  logic        recalibrate,
    output logic [15:0] rate_x,
    output logic [15:0] rate_y,
    output logic [15:0] rate_z,
    output logic        rate_valid,
    output logic [15:0] bias_x,
    output logic [15:0] bias_y,
    output logic [15:0] bias_z,
    output logic        calibrated
);

    localparam int                  c_acc_w    = 16 + CAL_LOG2;
    localparam int                  c_cnt_w    = CAL_LOG2 + 1;
    localparam logic [c_cnt_w-1:0]  c_cal_last = c_cnt_w'((1 << CAL_LOG2) - 1);
    localparam logic [16:0]         c_thresh   = 17'(MOTION_THRESH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                      r_dr_prev;
    logic                      w_accept;
    logic [2:0][15:0]          w_sample;

    // calibration datapath
    logic [2:0][c_acc_w-1:0]   r_acc;
    logic [2:0][15:0]          r_ref;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [2:0][15:0]          r_bias;

    logic [2:0][16:0]          w_diff;
    logic [2:0][16:0]          w_absdiff;
    logic [2:0][c_acc_w-1:0]   w_sext;
    logic [2:0][c_acc_w-1:0]   w_sum;
    logic [2:0][15:0]          w_bias_new;
    logic                      w_motion;

    logic                      w_cal_done;
    logic                      w_cal_fresh;
    logic                      w_load_first;

    // rate pipeline
    logic                      r_s1_valid;
    logic [2:0][15:0]          r_s1;
    logic [2:0][16:0]          w_rdiff;
    logic [2:0][15:0]          w_rate_sat;
    logic [2:0][15:0]          r_rate;
    logic                      r_rate_valid;

    // index 0 = x, 1 = y, 2 = z
    assign w_sample = {gyro_z_in, gyro_y_in, gyro_x_in};

    // A sample is taken only on the rising edge of data_ready
    assign w_accept = data_ready & ~r_dr_prev;

    // Remember last data_ready level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dr_prev <= 1'b0;
        end else begin
            r_dr_prev <= data_ready;
        end
    end

    // Per-axis arithmetic: motion check, accumulate, average, correct, saturate
    always_comb begin
        w_diff     = '0;
        w_absdiff  = '0;
        w_sext     = '0;
        w_sum      = '0;
        w_bias_new = '0;
        w_rdiff    = '0;
        w_rate_sat = '0;
        w_motion   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_diff[i]    = {w_sample[i][15], w_sample[i]} - {r_ref[i][15], r_ref[i]};
            w_absdiff[i] = w_diff[i][16] ? (17'd0 - w_diff[i]) : w_diff[i];
            if (w_absdiff[i] > c_thresh) begin
                w_motion = 1'b1;
            end
            w_sext[i]     = {{CAL_LOG2{w_sample[i][15]}}, w_sample[i]};
            w_sum[i]      = r_acc[i] + w_sext[i];
            w_bias_new[i] = 16'($signed(w_sum[i]) >>> CAL_LOG2);
            w_rdiff[i]    = {r_s1[i][15], r_s1[i]} - {r_bias[i][15], r_bias[i]};
            if (w_rdiff[i][16] != w_rdiff[i][15]) begin
                w_rate_sat[i] = w_rdiff[i][16] ? 16'h8000 : 16'h7FFF;
            end else begin
                w_rate_sat[i] = w_rdiff[i][15:0];
            end
        end
    end

    // Calibration control: completion, fresh start, and first-sample loading.
    // A sample arriving with a restart (recalibrate, motion, or empty run)
    // becomes the reference and first sample of the new run.
    always_comb begin
        w_cal_done   = 1'b0;
        w_cal_fresh  = 1'b0;
        w_load_first = 1'b0;
        if (!booting) begin
            w_cal_fresh = (r_state == ST_IDLE) || recalibrate;
            if (r_state == ST_CAL && w_accept && !recalibrate &&
                r_cnt != '0 && !w_motion && r_cnt == c_cal_last) begin
                w_cal_done = 1'b1;
            end
            if (w_accept) begin
                if (r_state == ST_RUN && recalibrate) begin
                    w_load_first = 1'b1;
                end else if (r_state == ST_CAL &&
                             (recalibrate || r_cnt == '0 || w_motion)) begin
                    w_load_first = 1'b1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; booting overrides everything
    always_comb begin
        w_state_next = r_state;
        if (booting) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_CAL;
                ST_CAL:  if (w_cal_done) w_state_next = ST_RUN;
                ST_RUN:  if (recalibrate) w_state_next = ST_CAL;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Accumulators, reference, sample counter and committed bias
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_ref  <= '0;
            r_cnt  <= '0;
            r_bias <= '0;
        end else begin
            if (w_cal_done) begin
                r_bias <= w_bias_new;
            end
            if (w_state_next == ST_CAL) begin
                if (w_load_first) begin
                    r_acc <= w_sext;
                    r_ref <= w_sample;
                    r_cnt <= c_cnt_w'(1);
                end else if (w_cal_fresh) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end else begin
                r_acc <= '0;
                r_cnt <= '0;
            end
        end
    end

    // Two-stage rate pipeline; anything in flight is dropped when RUN is left
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1         <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept && (r_state == ST_RUN) && (w_state_next == ST_RUN);
            if (w_accept) begin
                r_s1 <= w_sample;
            end
            r_rate_valid <= r_s1_valid && (w_state_next == ST_RUN);
            if (r_s1_valid && (w_state_next == ST_RUN)) begin
                r_rate <= w_rate_sat;
            end
        end
    end

    assign rate_x     = r_rate[0];
    assign rate_y     = r_rate[1];
    assign rate_z     = r_rate[2];
    assign rate_valid = r_rate_valid;
    assign bias_x     = r_bias[0];
    assign bias_y     = r_bias[1];
    assign bias_z     = r_bias[2];
    assign calibrated = (r_state == ST_RUN);

endmodule
`default_nettype wire
